// File: rtl/dem_switching_block_ns.sv
// rtl/dem_switching_block_ns.sv - DEM tree switching block: splits x into (x+s)/2 and (x-s)/2 with random or first-order shaped sign
// Optional feature macro: DEM_SB_IMBALANCE_EN (adds saturating imbalance_o counter)
module dem_switching_block_ns #(
    parameter int          WIDTH     = 5,
    parameter int          PN_SRC    = 0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          IMB_W     = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [WIDTH-1:0]        x_in_i,
    input  logic                    mode_i,
    input  logic                    pn_seq_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [WIDTH-1:0]        x_out1_o,
    output logic [WIDTH-1:0]        x_out2_o,
    output logic [1:0]              s_out_o
`ifdef DEM_SB_IMBALANCE_EN
    ,
    output logic signed [IMB_W-1:0] imbalance_o
`endif
);

    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;

    localparam logic [1:0] S_ZERO = 2'b00;
    localparam logic [1:0] S_POS  = 2'b01;
    localparam logic [1:0] S_NEG  = 2'b11;

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] x1_q, x1_d;
    logic [WIDTH-1:0] x2_q, x2_d;
    logic [1:0]       s_q, s_d;
    logic [1:0]       acc_q, acc_d;
    logic [15:0]      lfsr_q, lfsr_d;

    logic             accept;
    logic             pn_bit;
    logic             lfsr_fb;
    logic [1:0]       s_sel;
    logic [WIDTH:0]   s_ext;
    logic [WIDTH:0]   sum_p;
    logic [WIDTH:0]   sum_m;

    assign ready_o = ~valid_q | ready_i;
    assign accept  = valid_i & ready_o;

    assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    assign pn_bit  = (PN_SRC == 1) ? pn_seq_i : lfsr_q[0];

    // acc == +1 steers to -1 and vice versa; a balanced acc falls back to the PN bit
    always_comb begin
        s_sel = S_ZERO;
        if (x_in_i[0]) begin
            if (mode_i && (acc_q == S_POS)) begin
                s_sel = S_NEG;
            end else if (mode_i && (acc_q == S_NEG)) begin
                s_sel = S_POS;
            end else begin
                s_sel = pn_bit ? S_POS : S_NEG;
            end
        end
    end

    // One extra bit keeps x+1 at full scale from wrapping before the halving shift
    assign s_ext = {{(WIDTH - 1){s_sel[1]}}, s_sel};
    assign sum_p = {1'b0, x_in_i} + s_ext;
    assign sum_m = {1'b0, x_in_i} - s_ext;

    always_comb begin
        valid_d = valid_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        s_d     = s_q;
        acc_d   = acc_q;
        lfsr_d  = lfsr_q;
        if (accept) begin
            valid_d = 1'b1;
            x1_d    = sum_p[WIDTH:1];
            x2_d    = sum_m[WIDTH:1];
            s_d     = s_sel;
            acc_d   = mode_i ? (acc_q + s_sel) : 2'b00;
            lfsr_d  = {lfsr_fb, lfsr_q[15:1]};
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            x1_q    <= '0;
            x2_q    <= '0;
            s_q     <= S_ZERO;
            acc_q   <= 2'b00;
            lfsr_q  <= SEED;
        end else begin
            valid_q <= valid_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            s_q     <= s_d;
            acc_q   <= acc_d;
            lfsr_q  <= lfsr_d;
        end
    end

    assign valid_o  = valid_q;
    assign x_out1_o = x1_q;
    assign x_out2_o = x2_q;
    assign s_out_o  = s_q;

`ifdef DEM_SB_IMBALANCE_EN
    localparam logic signed [IMB_W:0] IMB_MAX = {2'b00, {(IMB_W - 1){1'b1}}};
    localparam logic signed [IMB_W:0] IMB_MIN = {2'b11, {(IMB_W - 2){1'b0}}, 1'b1};

    logic signed [IMB_W-1:0] imb_q, imb_d;
    logic signed [IMB_W:0]   imb_sum;

    assign imb_sum = $signed({imb_q[IMB_W-1], imb_q}) + $signed({{(IMB_W - 1){s_sel[1]}}, s_sel});

    // Clamp symmetrically so the counter never wraps
    always_comb begin
        imb_d = imb_q;
        if (accept) begin
            if (imb_sum > IMB_MAX) begin
                imb_d = IMB_MAX[IMB_W-1:0];
            end else if (imb_sum < IMB_MIN) begin
                imb_d = IMB_MIN[IMB_W-1:0];
            end else begin
                imb_d = imb_sum[IMB_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            imb_q <= '0;
        end else begin
            imb_q <= imb_d;
        end
    end

    assign imbalance_o = imb_q;
`endif

endmodule

// File: tb/tb_dem_switching_block_ns.sv
// tb/tb_dem_switching_block_ns.sv - bench for dem_switching_block_ns: external-PN and internal-LFSR instances against a behavioural model
module tb_dem_switching_block_ns;

    localparam int W     = 5;
    localparam int IMB_W = 4;

    logic clk;
    logic reset_i;
    logic valid_i;
    logic [W-1:0] x_in_i;
    logic mode_i;
    logic pn_seq_i;
    logic ready_i;

    logic         o_rdy[2];
    logic         o_vld[2];
    logic [W-1:0] o_x1[2];
    logic [W-1:0] o_x2[2];
    logic [1:0]   o_s[2];
`ifdef DEM_SB_IMBALANCE_EN
    logic signed [IMB_W-1:0] o_imb[2];
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state: index 0 = external PN, 1 = internal LFSR
    bit          m_v[2];
    int          m_x1[2];
    int          m_x2[2];
    int          m_s[2];
    int          m_acc[2];
    int          m_imb[2];
    logic [15:0] m_lfsr;

    dem_switching_block_ns #(.WIDTH(W), .PN_SRC(1), .LFSR_SEED(16'hACE1), .IMB_W(IMB_W)) u_ext (
        .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(o_rdy[0]),
        .x_in_i(x_in_i), .mode_i(mode_i), .pn_seq_i(pn_seq_i), .valid_o(o_vld[0]),
        .ready_i(ready_i), .x_out1_o(o_x1[0]), .x_out2_o(o_x2[0]), .s_out_o(o_s[0])
`ifdef DEM_SB_IMBALANCE_EN
        , .imbalance_o(o_imb[0])
`endif
    );

    dem_switching_block_ns #(.WIDTH(W), .PN_SRC(0), .LFSR_SEED(16'hACE1), .IMB_W(IMB_W)) u_lfsr (
        .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(o_rdy[1]),
        .x_in_i(x_in_i), .mode_i(mode_i), .pn_seq_i(pn_seq_i), .valid_o(o_vld[1]),
        .ready_i(ready_i), .x_out1_o(o_x1[1]), .x_out2_o(o_x2[1]), .s_out_o(o_s[1])
`ifdef DEM_SB_IMBALANCE_EN
        , .imbalance_o(o_imb[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int s_enc(input int s);
        return (s > 0) ? 1 : (s < 0) ? 3 : 0;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_v[k] = 0; m_x1[k] = 0; m_x2[k] = 0; m_s[k] = 0; m_acc[k] = 0; m_imb[k] = 0;
        end
        m_lfsr = 16'hACE1;
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_valid%0d", tag, k), int'(o_vld[k]), int'(m_v[k]));
            chk($sformatf("%s_ready%0d", tag, k), int'(o_rdy[k]), int'(!m_v[k] || ready_i));
            if (m_v[k]) begin
                chk($sformatf("%s_x1_%0d", tag, k), int'(o_x1[k]), m_x1[k]);
                chk($sformatf("%s_x2_%0d", tag, k), int'(o_x2[k]), m_x2[k]);
                chk($sformatf("%s_s%0d", tag, k), int'(o_s[k]), s_enc(m_s[k]));
            end
`ifdef DEM_SB_IMBALANCE_EN
            chk($sformatf("%s_imb%0d", tag, k), int'(o_imb[k]), m_imb[k]);
`endif
        end
    endtask

    // Drive one cycle of inputs, advance the model, check both instances after the edge
    task automatic step(input string tag, input bit v, input int x, input bit m, input bit pn, input bit r);
        bit acc_ok;
        int s;
        int p;
        int lim;
        valid_i  = v;
        x_in_i   = x[W-1:0];
        mode_i   = m;
        pn_seq_i = pn;
        ready_i  = r;
        lim      = (1 << (IMB_W - 1)) - 1;
        for (int k = 0; k < 2; k++) begin
            acc_ok = v && (!m_v[k] || r);
            if (acc_ok) begin
                p = (k == 0) ? int'(pn) : int'(m_lfsr[0]);
                if (x % 2 == 0)                s = 0;
                else if (m && m_acc[k] > 0)    s = -1;
                else if (m && m_acc[k] < 0)    s = 1;
                else                           s = p ? 1 : -1;
                m_s[k]   = s;
                m_x1[k]  = (x + s) / 2;
                m_x2[k]  = (x - s) / 2;
                m_acc[k] = m ? m_acc[k] + s : 0;
                m_imb[k] = m_imb[k] + s;
                if (m_imb[k] > lim)  m_imb[k] = lim;
                if (m_imb[k] < -lim) m_imb[k] = -lim;
                m_v[k]   = 1;
            end else if (r) begin
                m_v[k] = 0;
            end
        end
        if (v && (!m_v[1] || r || acc_ok))
            m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        @(posedge clk);
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    initial begin
        reset_i  = 1'b1;
        valid_i  = 1'b0;
        x_in_i   = '0;
        mode_i   = 1'b0;
        pn_seq_i = 1'b0;
        ready_i  = 1'b1;
        model_reset();
        #12;
        for (int k = 0; k < 2; k++) begin
            chk("reset_valid", int'(o_vld[k]), 0);
            chk("reset_x1", int'(o_x1[k]), 0);
            chk("reset_x2", int'(o_x2[k]), 0);
            chk("reset_s", int'(o_s[k]), 0);
        end
        @(negedge clk);
        reset_i = 1'b0;

        // Mode 0 with external PN
        step("d_x3", 1, 3, 0, 1, 1);
        chk("ex_x3_x1", int'(o_x1[0]), 2); chk("ex_x3_x2", int'(o_x2[0]), 1); chk("ex_x3_s", int'(o_s[0]), 1);
        step("d_x5", 1, 5, 0, 0, 1);
        chk("ex_x5_x1", int'(o_x1[0]), 2); chk("ex_x5_x2", int'(o_x2[0]), 3); chk("ex_x5_s", int'(o_s[0]), 3);
        step("d_x4", 1, 4, 0, 1, 1);
        chk("ex_x4_x1", int'(o_x1[0]), 2); chk("ex_x4_x2", int'(o_x2[0]), 2); chk("ex_x4_s", int'(o_s[0]), 0);

        // Boundaries
        step("d_x31", 1, 31, 0, 1, 1);
        chk("ex_x31_x1", int'(o_x1[0]), 16); chk("ex_x31_x2", int'(o_x2[0]), 15);
        step("d_x0", 1, 0, 0, 1, 1);
        chk("ex_x0_x1", int'(o_x1[0]), 0); chk("ex_x0_s", int'(o_s[0]), 0);

        // Mode 1 alternation with PN held 0
        step("m1_a", 1, 7, 1, 0, 1); chk("m1_s_a", int'(o_s[0]), 3);
        step("m1_b", 1, 7, 1, 0, 1); chk("m1_s_b", int'(o_s[0]), 1);
        step("m1_c", 1, 7, 1, 0, 1); chk("m1_s_c", int'(o_s[0]), 3);
        step("m1_d", 1, 7, 1, 0, 1); chk("m1_s_d", int'(o_s[0]), 1);

        // Back-pressure: hold the same pending sample for 3 cycles
        step("bp_load", 1, 9, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            step("bp_hold", 1, 11, 1, 0, 0);
            chk("bp_ready", int'(o_rdy[0]), 0);
            chk("bp_x1_stable", int'(o_x1[0]), 5);
        end
        step("bp_release", 1, 11, 1, 0, 1);
        chk("bp_after_x1", int'(o_x1[0]), 5);
        step("bp_drain", 0, 0, 0, 0, 1);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step("rnd", 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
        end

        // Reset mid-stream
        step("pre_rst", 1, 13, 1, 1, 0);
        reset_i = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("mid_rst_valid", int'(o_vld[k]), 0);
            chk("mid_rst_x1", int'(o_x1[k]), 0);
            chk("mid_rst_x2", int'(o_x2[k]), 0);
            chk("mid_rst_s", int'(o_s[k]), 0);
        end
        @(negedge clk);
        reset_i = 1'b0;
        model_reset();
        step("post_rst", 1, 7, 1, 0, 1);
        chk("post_rst_acc_cleared", int'(o_s[0]), 3);

`ifdef DEM_SB_IMBALANCE_EN
        @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        model_reset();
        for (int i = 0; i < 10; i++) step("imb", 1, 2 * i + 1, 0, 1, 1);
        chk("imb_saturate", int'(o_imb[0]), 7);
`endif

        for (int i = 0; i < 200; i++) begin
            step("rnd2", 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
